// File: rtl/dc7_seq_checker_if.sv
// Counter-bus bundle between a skip-down counter source and its checker.
// The source drives data/valid; the checker returns lock status and event flags.
interface dc7_seq_checker_if #(
    parameter int WIDTH = 7,
    parameter int ERR_W = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             locked;
    logic [WIDTH-1:0] expected;
    logic             err_pulse;
    logic             skip_pulse;
    logic             wrap_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output data_in, valid_in,
        input  locked, expected, err_pulse, skip_pulse, wrap_pulse, err_count
    );

    modport slave (
        input  data_in, valid_in,
        output locked, expected, err_pulse, skip_pulse, wrap_pulse, err_count
    );
endinterface

// File: rtl/dc7_seq_checker.sv
// Receive-side checker for a skip-down counter stream: predicts the next legal
// value, locks after a run of correct transitions and flags misses while locked.
module dc7_seq_checker #(
    parameter int WIDTH      = 7,
    parameter int STEP       = 2,
    parameter int SKIP       = 7,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input logic               clock,
    input logic               reset,
    dc7_seq_checker_if.slave  bus
);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

    localparam logic [WIDTH-1:0]   STEP_V  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0]   STEP2_V = WIDTH'(2 * STEP);
    localparam logic [WIDTH-1:0]   SKIP_V  = WIDTH'(SKIP);
    localparam logic [MATCH_W-1:0] LOCK_V  = MATCH_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]  LOSS_V  = MISS_W'(LOSS_COUNT);

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] CONFIRM = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    logic [1:0]         state;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic [WIDTH-1:0]   expected;
    logic               locked;
    logic               err_pulse;
    logic               skip_pulse;
    logic               wrap_pulse;
    logic [ERR_W-1:0]   err_count;

    logic [WIDTH-1:0]   sample;
    logic [WIDTH-1:0]   nxt_sample;
    logic [WIDTH-1:0]   nxt_expected;

    // Successor of v in the generator sequence; the forbidden value is jumped over.
    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] t;
        t = v - STEP_V;
        if (t == SKIP_V) t = v - STEP2_V;
        return t;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (c == {ERR_W{1'b1}}) ? c : c + ERR_W'(1);
    endfunction

    assign sample       = bus.data_in;
    assign nxt_sample   = nxt(sample);
    assign nxt_expected = nxt(expected);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= HUNT;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            expected   <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            skip_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
        end else begin
            err_pulse  <= 1'b0;
            skip_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            if (bus.valid_in) begin
                skip_pulse <= (sample == SKIP_V);
                case (state)
                    HUNT: begin
                        expected  <= nxt_sample;
                        match_cnt <= '0;
                        state     <= CONFIRM;
                    end
                    CONFIRM: begin
                        expected <= nxt_sample;
                        if (sample == expected) begin
                            match_cnt <= match_cnt + MATCH_W'(1);
                            if (match_cnt + MATCH_W'(1) == LOCK_V) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (sample == expected) begin
                            expected   <= nxt_sample;
                            miss_cnt   <= '0;
                            wrap_pulse <= (nxt_sample > sample);
                        end else begin
                            // Flywheel: keep predicting from our own sequence, not the bad sample.
                            err_pulse <= 1'b1;
                            err_count <= sat_inc(err_count);
                            expected  <= nxt_expected;
                            if (miss_cnt + MISS_W'(1) == LOSS_V) begin
                                state     <= HUNT;
                                locked    <= 1'b0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked     = locked;
    assign bus.expected   = expected;
    assign bus.err_pulse  = err_pulse;
    assign bus.skip_pulse = skip_pulse;
    assign bus.wrap_pulse = wrap_pulse;
    assign bus.err_count  = err_count;
endmodule
